// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Parametrised register file with two write ports (ALU and load
//             writeback), two combinational read ports with optional write
//             bypass, a per-register pending-write scoreboard and a
//             sequenced clear that zeroes one register per cycle.
//  Ports    : clk, rst_n           clock, async active-low reset
//             i_wr0_*              write port 0 (ALU writeback)
//             i_wr1_*              write port 1 (load writeback, wins ties)
//             i_rd0/1_addr         read addresses
//             o_rd0/1_data         read data (combinational)
//             o_rd0/1_busy         addressed register has a pending write
//             i_mark_en/_addr      mark a destination pending at issue
//             i_clr_req            start a clear sequence
//             o_clr_busy           clear sequence in progress
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  input  logic [ADDR_W-1:0] i_rd0_addr,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  output logic [DATA_W-1:0] o_rd0_data,
  output logic [DATA_W-1:0] o_rd1_data,
  output logic              o_rd0_busy,
  output logic              o_rd1_busy,
  input  logic              i_mark_en,
  input  logic [ADDR_W-1:0] i_mark_addr,
  input  logic              i_clr_req,
  output logic              o_clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_busy;

  logic                w_idle;
  logic                w_clr_start;
  logic                w_wr0_ok;
  logic                w_wr1_ok;
  logic                w_mark_ok;

  assign w_idle      = (r_state == S_IDLE);
  assign w_clr_start = w_idle && i_clr_req;

  // Effective enables: only in IDLE, and address 0 is dropped when hardwired.
  assign w_wr0_ok  = w_idle && i_wr0_en &&
                     !((ZERO_REG != 0) && (i_wr0_addr == '0));
  assign w_wr1_ok  = w_idle && i_wr1_en &&
                     !((ZERO_REG != 0) && (i_wr1_addr == '0));
  assign w_mark_ok = w_idle && i_mark_en &&
                     !((ZERO_REG != 0) && (i_mark_addr == '0));

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_start) begin
        r_cnt <= '0;
      end else if (r_state == S_CLEAR) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_clr_req) w_state_nxt = S_CLEAR;
      // Explicit terminal compare rather than relying on counter wrap.
      S_CLEAR: if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_clr_busy = (r_state == S_CLEAR);

  // --------------------------------------------------------------------------
  // Storage and scoreboard, one slice per register
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic w_hit0;
    logic w_hit1;
    logic w_mark;
    logic w_clr_me;

    assign w_hit0   = w_wr0_ok  && (i_wr0_addr  == ADDR_W'(i));
    assign w_hit1   = w_wr1_ok  && (i_wr1_addr  == ADDR_W'(i));
    assign w_mark   = w_mark_ok && (i_mark_addr == ADDR_W'(i));
    assign w_clr_me = (r_state == S_CLEAR) && (r_cnt == ADDR_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[i] <= '0;
      end else if (w_clr_me) begin
        r_mem[i] <= '0;
      end else if (w_hit1) begin
        r_mem[i] <= i_wr1_data;
      end else if (w_hit0) begin
        r_mem[i] <= i_wr0_data;
      end
    end

    // A mark in the same cycle as a write belongs to a newer instruction,
    // so it takes precedence over the write's release of the pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy[i] <= 1'b0;
      end else if (w_clr_start) begin
        r_busy[i] <= 1'b0;
      end else if (w_mark) begin
        r_busy[i] <= 1'b1;
      end else if (w_hit0 || w_hit1) begin
        r_busy[i] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_rd_busy [2];

  assign w_rd_addr[0] = i_rd0_addr;
  assign w_rd_addr[1] = i_rd1_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_zero;
    logic w_byp0;
    logic w_byp1;

    assign w_zero = (ZERO_REG != 0) && (w_rd_addr[p] == '0);
    // w_wrN_ok already excludes CLEAR, so bypass is off during a clear.
    assign w_byp0 = (BYPASS != 0) && w_wr0_ok && (i_wr0_addr == w_rd_addr[p]);
    assign w_byp1 = (BYPASS != 0) && w_wr1_ok && (i_wr1_addr == w_rd_addr[p]);

    always_comb begin
      w_rd_data[p] = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = r_busy[w_rd_addr[p]];
      if (w_zero) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end else if (w_byp1) begin
        w_rd_data[p] = i_wr1_data;
        w_rd_busy[p] = 1'b0;
      end else if (w_byp0) begin
        w_rd_data[p] = i_wr0_data;
        w_rd_busy[p] = 1'b0;
      end else if (!w_idle) begin
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign o_rd0_data = w_rd_data[0];
  assign o_rd1_data = w_rd_data[1];
  assign o_rd0_busy = w_rd_busy[0];
  assign o_rd1_busy = w_rd_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb. Two instances share all
//             inputs: u_dut_z (ZERO_REG=1) and u_dut_n (ZERO_REG=0). A
//             behavioural model of both register files predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        wr0_en, wr1_en, mark_en, clr_req;
  logic [2:0]  wr0_addr, wr1_addr, rd0_addr, rd1_addr, mark_addr;
  logic [15:0] wr0_data, wr1_data;

  logic [1:0][15:0] rd0_data, rd1_data;
  logic [1:0]       rd0_busy, rd1_busy, clr_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
  logic [15:0] m_mem  [2][8];
  logic        m_busy [2][8];
  int          m_clr_left;   // remaining clear cycles, 0 = idle

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_rd0_addr(rd0_addr), .i_rd1_addr(rd1_addr),
    .o_rd0_data(rd0_data[0]), .o_rd1_data(rd1_data[0]),
    .o_rd0_busy(rd0_busy[0]), .o_rd1_busy(rd1_busy[0]),
    .i_mark_en(mark_en), .i_mark_addr(mark_addr),
    .i_clr_req(clr_req), .o_clr_busy(clr_busy[0])
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_rd0_addr(rd0_addr), .i_rd1_addr(rd1_addr),
    .o_rd0_data(rd0_data[1]), .o_rd1_data(rd1_data[1]),
    .o_rd0_busy(rd0_busy[1]), .o_rd1_busy(rd1_busy[1]),
    .i_mark_en(mark_en), .i_mark_addr(mark_addr),
    .i_clr_req(clr_req), .o_clr_busy(clr_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_zero(int k, logic [2:0] a);
    return (k == 0) && (a == 3'd0);
  endfunction

  function automatic logic [15:0] exp_data(int k, logic [2:0] a);
    if (m_zero(k, a)) return 16'h0;
    if (m_clr_left == 0) begin
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
    end
    return m_mem[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [2:0] a);
    if (m_zero(k, a) || m_clr_left != 0) return 1'b0;
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) begin
        m_mem[k][a]  = 16'h0;
        m_busy[k][a] = 1'b0;
      end
    m_clr_left = 0;
  endtask

  // Apply one clock edge worth of architectural effect.
  task automatic model_step();
    if (m_clr_left != 0) begin
      for (int k = 0; k < 2; k++) m_mem[k][8 - m_clr_left] = 16'h0;
      m_clr_left--;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr0_en && !m_zero(k, wr0_addr)) begin
          m_mem[k][wr0_addr] = wr0_data; m_busy[k][wr0_addr] = 1'b0;
        end
        if (wr1_en && !m_zero(k, wr1_addr)) begin
          m_mem[k][wr1_addr] = wr1_data; m_busy[k][wr1_addr] = 1'b0;
        end
        if (mark_en && !m_zero(k, mark_addr)) m_busy[k][mark_addr] = 1'b1;
        if (clr_req) for (int a = 0; a < 8; a++) m_busy[k][a] = 1'b0;
      end
      if (clr_req) m_clr_left = 8;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d_rd0_data", k), 32'(rd0_data[k]), 32'(exp_data(k, rd0_addr)));
      chk($sformatf("i%0d_rd1_data", k), 32'(rd1_data[k]), 32'(exp_data(k, rd1_addr)));
      chk($sformatf("i%0d_rd0_busy", k), 32'(rd0_busy[k]), 32'(exp_busy(k, rd0_addr)));
      chk($sformatf("i%0d_rd1_busy", k), 32'(rd1_busy[k]), 32'(exp_busy(k, rd1_addr)));
      chk($sformatf("i%0d_clr_busy", k), 32'(clr_busy[k]), 32'(m_clr_left != 0));
    end
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr1_en = 0; mark_en = 0; clr_req = 0;
  endtask

  // Inputs are already set in the low phase; check, take the edge, advance.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    idle_inputs();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse clr_req then count clear cycles, bounded.
  task automatic run_clear(input bool_wr6);
    int cnt;
    clr_req = 1; cycle(); clr_req = 0;
    cnt = 0;
    for (int i = 0; i < 20 && clr_busy[0]; i++) begin
      if (bool_wr6 && i == 2) begin
        wr0_en = 1; wr0_addr = 3'd6; wr0_data = 16'hBEEF;
      end
      cycle();
      idle_inputs();
      cnt++;
    end
    chk("clr_len", 32'(cnt), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    wr0_addr = 0; wr1_addr = 0; rd0_addr = 0; rd1_addr = 0; mark_addr = 0;
    wr0_data = 0; wr1_data = 0;
    @(negedge clk);
    do_reset();

    // Reset state on every address.
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(7 - a);
      #1;
      check_all();
      chk("rst_data", 32'(rd0_data[1]), 32'h0);
    end

    // Same-address dual write: wr1 wins, bypass returns it.
    wr0_en = 1; wr0_addr = 3; wr0_data = 16'hA5A5;
    wr1_en = 1; wr1_addr = 3; wr1_data = 16'h1234;
    rd0_addr = 3;
    #1 chk("byp_r3", 32'(rd0_data[0]), 32'h1234);
    cycle(); idle_inputs();
    #1 chk("r3_hold", 32'(rd0_data[0]), 32'h1234);
    cycle();

    // Scoreboard on r5.
    mark_en = 1; mark_addr = 5; rd1_addr = 5;
    cycle(); idle_inputs();
    #1 chk("busy5_set", 32'(rd1_busy[0]), 32'h1);
    wr0_en = 1; wr0_addr = 5; wr0_data = 16'h00FF;
    #1 chk("busy5_byp", 32'(rd1_busy[0]), 32'h0);
    chk("data5_byp", 32'(rd1_data[0]), 32'h00FF);
    cycle(); idle_inputs();
    #1 chk("busy5_clr", 32'(rd1_busy[0]), 32'h0);
    mark_en = 1; mark_addr = 5; wr0_en = 1; wr0_addr = 5; wr0_data = 16'h0F0F;
    cycle(); idle_inputs();
    #1 chk("busy5_mark_wins", 32'(rd1_busy[0]), 32'h1);

    // Hardwired zero vs ordinary r0.
    wr0_en = 1; wr0_addr = 0; wr0_data = 16'hFFFF; mark_en = 1; mark_addr = 0;
    rd0_addr = 0;
    cycle(); idle_inputs();
    #1 chk("zr_data", 32'(rd0_data[0]), 32'h0);
    chk("zr_busy", 32'(rd0_busy[0]), 32'h0);
    chk("nz_data", 32'(rd0_data[1]), 32'hFFFF);
    chk("nz_busy", 32'(rd0_busy[1]), 32'h1);

    // Fill r1..r7, mark r2, clear with a write to r6 issued mid-sequence.
    for (int a = 1; a < 8; a++) begin
      wr0_en = 1; wr0_addr = 3'(a); wr0_data = 16'(16'h1110 * a + 1);
      cycle();
    end
    idle_inputs();
    mark_en = 1; mark_addr = 2; cycle(); idle_inputs();
    run_clear(1'b1);
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(a);
      #1;
      chk("post_clr_data", 32'(rd0_data[1]), 32'h0);
      chk("post_clr_busy", 32'(rd1_busy[1]), 32'h0);
      check_all();
    end

    // Reset during the 4th clear cycle aborts the sequence.
    for (int a = 1; a < 8; a++) begin
      wr1_en = 1; wr1_addr = 3'(a); wr1_data = 16'($urandom) | 16'h1;
      cycle();
    end
    idle_inputs();
    clr_req = 1; cycle(); clr_req = 0;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1 chk("rst_abort", 32'(clr_busy[0]), 32'h0);
    @(negedge clk);
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(a);
      #1 check_all();
    end
    run_clear(1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr0_en = 1'($urandom); wr0_addr = 3'($urandom); wr0_data = 16'($urandom);
      wr1_en = 1'($urandom); wr1_addr = 3'($urandom); wr1_data = 16'($urandom);
      mark_en = 1'($urandom); mark_addr = 3'($urandom);
      rd0_addr = 3'($urandom); rd1_addr = 3'($urandom);
      clr_req = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
